// File: rtl/ualink_crc_pkg.sv
// Shared CRC-8 constants, FSM encodings and beat payload type for the UALink
// turbo64 CRC generator/checker pair.
package ualink_crc_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned CRC_W   = 8;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned N_BYTES = DATA_W / BYTE_W;

  localparam logic [CRC_W-1:0] CRC8_POLY = 8'h07;
  localparam logic [CRC_W-1:0] CRC8_INIT = 8'h00;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              crc_err;
  } rx_beat_t;

  // Table entry for index idx: eight MSB-first shifts of the polynomial.
  function automatic logic [CRC_W-1:0] crc8_table(input logic [BYTE_W-1:0] idx);
    logic [CRC_W-1:0] c;
    c = idx;
    for (int b = 0; b < BYTE_W; b++) begin
      c = c[CRC_W-1] ? ({c[CRC_W-2:0], 1'b0} ^ CRC8_POLY) : {c[CRC_W-2:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [CRC_W-1:0] crc8_byte(input logic [CRC_W-1:0] crc,
                                                 input logic [BYTE_W-1:0] data);
    return crc8_table(crc ^ data);
  endfunction

endpackage

// File: rtl/crc8_64bit_step.sv
// Combinational CRC-8 update over one 64-bit beat, most significant byte first.
module crc8_64bit_step
  import ualink_crc_pkg::*;
(
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < N_BYTES; i++) begin
      crc_out = crc8_byte(crc_out, data[DATA_W-1-BYTE_W*i -: BYTE_W]);
    end
  end

endmodule

// File: rtl/ualink_crc8_rx_checker.sv
// Receive-side CRC-8 checker: cut-through forwarding through one register stage,
// per-packet pass/fail on the eop beat, saturating packet/error/drop counters.
module ualink_crc8_rx_checker
  import ualink_crc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CRC_W-1:0]  in_crc,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_crc_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int unsigned SUM_W = CNT_W + 1;

  rx_state_e        state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic             out_valid_q, out_valid_d;
  rx_beat_t         beat_q, beat_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             accept;
  logic             fwd;
  logic             trunc;
  logic             drop;
  logic             mismatch;
  logic [CRC_W-1:0] crc_seed;
  logic [CRC_W-1:0] crc_next;
  logic [1:0]       err_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + SUM_W'(inc);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Every sop restarts the running CRC, including a truncating restart.
  assign crc_seed = in_sop ? CRC8_INIT : crc_q;
  assign mismatch = crc_next != in_crc;

  crc8_64bit_step u_step (
    .crc_in  (crc_seed),
    .data    (in_data),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    fwd     = 1'b0;
    trunc   = 1'b0;
    drop    = 1'b0;
    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_sop) begin
            fwd     = 1'b1;
            crc_d   = in_eop ? CRC8_INIT : crc_next;
            state_d = in_eop ? ST_IDLE : ST_IN_PKT;
          end else begin
            drop = 1'b1;
          end
        end
        ST_IN_PKT: begin
          fwd     = 1'b1;
          trunc   = in_sop;
          crc_d   = in_eop ? CRC8_INIT : crc_next;
          state_d = in_eop ? ST_IDLE : ST_IN_PKT;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    beat_d      = beat_q;
    if (accept && fwd) begin
      out_valid_d    = 1'b1;
      beat_d.data    = in_data;
      beat_d.sop     = in_sop;
      beat_d.eop     = in_eop;
      beat_d.crc_err = in_eop && mismatch;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // A truncation and a failing eop in the same beat add two errors.
  always_comb begin
    err_inc    = 2'(accept && fwd && in_eop && mismatch) + 2'(trunc);
    pkt_cnt_d  = sat_add(pkt_cnt_q, 2'(accept && fwd && in_eop));
    err_cnt_d  = sat_add(err_cnt_q, err_inc);
    drop_cnt_d = sat_add(drop_cnt_q, 2'(drop));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC8_INIT;
      out_valid_q <= 1'b0;
      beat_q      <= '0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      out_valid_q <= out_valid_d;
      beat_q      <= beat_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = beat_q.data;
  assign out_sop     = beat_q.sop;
  assign out_eop     = beat_q.eop;
  assign out_crc_err = beat_q.crc_err;
  assign pkt_count   = pkt_cnt_q;
  assign err_count   = err_cnt_q;
  assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_ualink_crc8_rx_checker.sv
// Directed bench for ualink_crc8_rx_checker; a narrow-counter instance checks saturation.
module tb_ualink_crc8_rx_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_crc = '0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_sop, out_eop, out_crc_err;
  logic [63:0] out_data;
  logic [31:0] pkt_count, err_count, drop_count;

  logic        s_in_ready, s_out_valid, s_out_sop, s_out_eop, s_out_crc_err;
  logic [63:0] s_out_data;
  logic [1:0]  s_pkt_count, s_err_count, s_drop_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ualink_crc8_rx_checker #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_crc(in_crc),
    .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_crc_err(out_crc_err), .out_valid(out_valid), .out_ready(out_ready),
    .pkt_count(pkt_count), .err_count(err_count), .drop_count(drop_count)
  );

  ualink_crc8_rx_checker #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_data(in_data), .in_crc(in_crc),
    .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_sop(s_out_sop), .out_eop(s_out_eop),
    .out_crc_err(s_out_crc_err), .out_valid(s_out_valid), .out_ready(out_ready),
    .pkt_count(s_pkt_count), .err_count(s_err_count), .drop_count(s_drop_count)
  );

  // Bit-serial reference CRC-8 (poly 0x07), MSB of the beat first.
  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [63:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 63; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic beat(input logic [63:0] d, input logic [7:0] c, input logic s, input logic e);
    int guard;
    in_data  = d;
    in_crc   = c;
    in_sop   = s;
    in_eop   = e;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_total++;
      $error("FAIL beat_timeout: observed in_ready=%0b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [63:0] bp_data [4];
  logic [7:0]  bp_crc;

  initial begin
    bp_data[0] = 64'h1111_2222_3333_4444;
    bp_data[1] = 64'hdead_beef_0123_4567;
    bp_data[2] = 64'h89ab_cdef_fedc_ba98;
    bp_data[3] = 64'h0f0f_f0f0_55aa_a55a;
    bp_crc = 8'h00;
    for (int i = 0; i < 4; i++) bp_crc = ref_crc(bp_crc, bp_data[i]);

    // Reset state
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_flags", 64'({out_sop, out_eop, out_crc_err}), 64'h0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_counters", 64'({pkt_count, err_count} | 64'(drop_count)), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single-beat packets: good then bad CRC
    beat(64'h0000_0000_0000_0001, 8'h07, 1'b1, 1'b1);
    chk("sb_valid", 64'(out_valid), 64'h1);
    chk("sb_flags", 64'({out_sop, out_eop, out_crc_err}), 64'b110);
    chk("sb_data", out_data, 64'h1);
    chk("sb_pkt", 64'(pkt_count), 64'd1);
    beat(64'h0000_0000_0000_0080, 8'h07, 1'b1, 1'b1);
    chk("sb_bad_err", 64'(out_crc_err), 64'h1);
    chk("sb_bad_errcnt", 64'(err_count), 64'd1);

    // Two-beat packets
    beat(64'h0, 8'h00, 1'b1, 1'b0);
    chk("tb0_flags", 64'({out_valid, out_sop, out_eop}), 64'b110);
    beat(64'h0000_0000_0000_0001, 8'h07, 1'b0, 1'b1);
    chk("tb1_flags", 64'({out_sop, out_eop, out_crc_err}), 64'b010);
    beat(64'h0, 8'h00, 1'b1, 1'b0);
    beat(64'h0000_0000_0000_0080, 8'h89, 1'b0, 1'b1);
    chk("tb2_err", 64'(out_crc_err), 64'h0);
    chk("tb2_pkt", 64'(pkt_count), 64'd4);
    chk("tb2_errcnt", 64'(err_count), 64'd1);
    @(posedge clk);
    #1;
    chk("idle_drain", 64'(out_valid), 64'h0);

    // Backpressure during a 4-beat packet
    beat(bp_data[0], 8'h00, 1'b1, 1'b0);
    out_ready = 1'b0;
    in_data = bp_data[1]; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'h0);
      chk("bp_hold_data", out_data, bp_data[0]);
      chk("bp_hold_valid", 64'({out_valid, out_sop}), 64'b11);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_b1", out_data, bp_data[1]);
    beat(bp_data[2], 8'h00, 1'b0, 1'b0);
    chk("bp_b2", out_data, bp_data[2]);
    beat(bp_data[3], bp_crc, 1'b0, 1'b1);
    chk("bp_b3", out_data, bp_data[3]);
    chk("bp_eop_ok", 64'({out_eop, out_crc_err}), 64'b10);
    chk("bp_pkt", 64'(pkt_count), 64'd5);

    // Stray beat, then truncation by a sop&eop restart
    beat(64'hbad0_bad0_bad0_bad0, 8'h00, 1'b0, 1'b0);
    chk("stray_not_fwd", 64'(out_valid), 64'h0);
    chk("stray_drop", 64'(drop_count), 64'd1);
    beat(64'h1234_5678_9abc_def0, 8'h00, 1'b1, 1'b0);
    beat(64'h0000_0000_0000_0001, 8'h07, 1'b1, 1'b1);
    chk("trunc_flags", 64'({out_sop, out_eop, out_crc_err}), 64'b110);
    chk("trunc_errcnt", 64'(err_count), 64'd2);
    chk("trunc_pkt", 64'(pkt_count), 64'd6);

    // Reset mid-packet
    beat(64'h5555_5555_5555_5555, 8'h00, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk("mrst_out", 64'({out_valid, out_sop, out_eop, out_crc_err}), 64'h0);
    chk("mrst_data", out_data, 64'h0);
    chk("mrst_cnt", 64'(pkt_count) | 64'(err_count) | 64'(drop_count), 64'h0);
    chk("mrst_ready", 64'(in_ready), 64'h1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    beat(64'h0000_0000_0000_0001, 8'h07, 1'b0, 1'b1);
    chk("mrst_drop_valid", 64'(out_valid), 64'h0);
    chk("mrst_drop_cnt", 64'(drop_count), 64'd1);
    chk("mrst_pkt", 64'(pkt_count), 64'd0);

    // Truncation and bad CRC in one beat: err_count += 2
    beat(64'h0, 8'h00, 1'b1, 1'b0);
    beat(64'h0000_0000_0000_0080, 8'h07, 1'b1, 1'b1);
    chk("dbl_err_flag", 64'(out_crc_err), 64'h1);
    chk("dbl_errcnt", 64'(err_count), 64'd2);
    chk("dbl_errcnt_narrow", 64'(s_err_count), 64'd2);
    beat(64'h0, 8'h00, 1'b1, 1'b0);
    beat(64'h0000_0000_0000_0080, 8'h07, 1'b1, 1'b1);
    chk("dbl2_errcnt", 64'(err_count), 64'd4);
    chk("sat_errcnt", 64'(s_err_count), 64'd3);

    // Drop counter saturation on the narrow instance
    for (int k = 0; k < 4; k++) beat(64'(k), 8'h00, 1'b0, 1'b0);
    chk("drop_wide", 64'(drop_count), 64'd5);
    chk("sat_drop", 64'(s_drop_count), 64'd3);
    chk("sat_pkt", 64'(s_pkt_count), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ualink_crc8_rx_checker.md
# ualink_crc8_rx_checker

Receive-side CRC-8 checker for the UALink turbo64 datapath. It sits downstream of the link receiver and upstream of the flit consumer. It accepts 64-bit beats framed by sop/eop, recomputes CRC-8 over every byte of the packet, and compares the result with the CRC byte delivered on the eop beat. Beats are forwarded cut-through through one register stage; a pass/fail flag accompanies the eop beat, and packet and error counters are maintained.

## Interface
Parameters:
- CNT_W, 32, width of the statistics counters (saturating)

Ports:
- clk  in  1  sole clock; all logic rising-edge
- reset  in  1  asynchronous, active-high
- in_data  in  64  beat payload; byte order MSB-first, [63:56] first on the wire
- in_crc  in  8  received CRC; sampled only on an accepted eop beat
- in_sop  in  1  first beat of packet
- in_eop  in  1  last beat of packet (sop and eop may coincide)
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- out_data  out  64  forwarded payload
- out_sop  out  1  forwarded sop
- out_eop  out  1  forwarded eop
- out_crc_err  out  1  meaningful only with out_eop: 1 = CRC mismatch or truncated packet
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts
- pkt_count  out  CNT_W  packets checked (eop beats forwarded)
- err_count  out  CNT_W  CRC mismatches plus truncated packets
- drop_count  out  CNT_W  beats discarded outside a packet

## Operation
- CRC: polynomial 0x07, init 0x00, no reflection, no final XOR.
- Running CRC starts at 0x00 on every sop and is carried across the beats of a packet. Each beat folds in 8 bytes, most significant byte first.
- Check: on an eop beat, compute the final CRC including that beat's data, then out_crc_err = (final != in_crc).
- FSM with two states, IDLE and IN_PKT. Transitions apply only on accepted beats.
  - IDLE + sop&!eop → IN_PKT. Beat forwarded.
  - IDLE + sop&eop → IDLE. Single-beat packet forwarded and checked.
  - IDLE + !sop → IDLE. Beat dropped (not forwarded); drop_count++.
  - IN_PKT + !sop&!eop → IN_PKT. Beat forwarded; CRC accumulated.
  - IN_PKT + !sop&eop → IDLE. Beat forwarded and checked.
  - IN_PKT + sop → previous packet is truncated; err_count++. CRC restarts with this beat, which is forwarded as a new sop. Next state is IN_PKT, or IDLE if eop is also set.
- Counters saturate at all-ones and never wrap.
- pkt_count increments when an eop beat enters the output register.
- err_count increments at the same point if out_crc_err is 1, and separately on each truncation event.
- If both increments occur in one cycle, err_count increases by 2 (still saturating).
- Truncated packets never receive a forwarded eop from this block. The downstream consumer sees a sop-restart.

## Timing
- Reset values:
  - out_valid, out_sop, out_eop, out_crc_err = 0
  - out_data = 0
  - all counters = 0
  - FSM = IDLE
  - running CRC = 0x00
  - in_ready = 1
- Latency: 1 cycle from accepted input beat to out_valid.
- in_ready = !out_valid || out_ready. This is combinational, with no input-to-ready path.
- Output register holds out_* stable while out_valid && !out_ready.
- Full throughput: one beat per cycle when out_ready is held at 1.
- CRC for a beat is computed combinationally from the registered running CRC plus in_data in the accept cycle. out_crc_err is registered alongside out_eop.
- Reset mid-packet: the packet is lost and the FSM returns to IDLE. Subsequent non-sop beats are dropped.

## Structure
- Shared package ualink_crc_pkg holds CRC8_POLY = 8'h07, CRC8_INIT = 8'h00, and the FSM state encodings. The transmit-side generator imports the same package.
- Sub-module crc8_64bit_step: combinational, inputs crc_in[7:0] and data[63:0], output crc_out[7:0]. It implements eight byte-serial table steps, MSB byte first. It is instantiated once; the checker owns all state.

## Test plan
- Single-beat packet, in_data = 64'h0000_0000_0000_0001, in_crc = 8'h07, sop=eop=1 → out_eop=1, out_crc_err=0, pkt_count=1.
- Same beat with in_data = 64'h0000_0000_0000_0080, in_crc = 8'h07 (correct value 8'h89) → out_crc_err=1, err_count=1.
- Two-beat packet: beat 0 = 64'h0, beat 1 = 64'h0000_0000_0000_0001, in_crc = 8'h07 → no error. Then the same packet with beat 1 = 64'h0000_0000_0000_0080 and in_crc = 8'h89 → no error. pkt_count=2.
- Backpressure: hold out_ready=0 for 5 cycles during a 4-beat packet → in_ready=0 while the output register is full, output stable, no beat lost or duplicated.
- Stray beat in IDLE (sop=0) → not forwarded, drop_count=1. Then sop without eop, then sop&eop with correct CRC → err_count=1 (truncation), pkt_count=1, out_crc_err=0.
- Assert reset for 1 cycle mid-packet → all outputs and counters return to 0, in_ready=1. The next non-sop beat is dropped.
